// File: rtl/mux_pkg.sv
// Shared definitions for the stream multiplexer: mode encodings and the
// round-robin search helper used by rr_arbiter.
package mux_pkg;

    localparam int unsigned RR_MAX_BITS  = 4;
    localparam int unsigned RR_MAX_CELLS = 1 << RR_MAX_BITS;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    typedef struct packed {
        logic                   found;
        logic [RR_MAX_BITS-1:0] idx;
    } rr_result_t;

    // Searches start+1, start+2, ... wrapping through mask (channel count - 1);
    // the final iteration revisits start itself, so every channel is covered.
    function automatic rr_result_t rr_find(
        input logic [RR_MAX_CELLS-1:0] valid,
        input logic [RR_MAX_BITS-1:0]  start,
        input logic [RR_MAX_BITS-1:0]  mask
    );
        rr_result_t             res;
        logic [RR_MAX_BITS-1:0] idx;
        res = '0;
        for (int unsigned k = 1; k <= RR_MAX_CELLS; k++) begin
            idx = (start + RR_MAX_BITS'(k)) & mask;
            if (!res.found && valid[idx]) begin
                res.found = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first requesting channel after i_ptr.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int unsigned switch_bits = 2
) (
    input  logic [(1 << switch_bits)-1:0] i_req,
    input  logic [switch_bits-1:0]        i_ptr,
    output logic [switch_bits-1:0]        o_idx,
    output logic                          o_found
);

    localparam int unsigned n_cell = 1 << switch_bits;
    localparam logic [RR_MAX_BITS-1:0] MASK = RR_MAX_BITS'(n_cell - 1);

    logic [RR_MAX_CELLS-1:0] w_req_ext;
    rr_result_t              w_res;

    always_comb begin
        w_req_ext              = '0;
        w_req_ext[n_cell-1:0]  = i_req;
    end

    assign w_res   = rr_find(w_req_ext, RR_MAX_BITS'(i_ptr), MASK);
    assign o_idx   = w_res.idx[switch_bits-1:0];
    assign o_found = w_res.found;

endmodule

// File: rtl/stream_mux.sv
// N-way stream multiplexer with select/round-robin arbitration, packet
// locking on last, and a registered full-throughput output stage.
module stream_mux
    import mux_pkg::*;
#(
    parameter int unsigned switch_bits = 2,
    parameter int unsigned data_width  = 8
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       mode,
    input  logic [switch_bits-1:0]                     sel,
    input  logic [(1 << switch_bits)-1:0]              in_valid,
    input  logic [(1 << switch_bits)*data_width-1:0]   in_data,
    input  logic [(1 << switch_bits)-1:0]              in_last,
    output logic [(1 << switch_bits)-1:0]              in_ready,
    output logic                                       o_valid,
    output logic [data_width-1:0]                      o_data,
    output logic                                       o_last,
    output logic [switch_bits-1:0]                     o_chan,
    input  logic                                       o_ready
);

    localparam int unsigned n_cell = 1 << switch_bits;

    logic                   r_valid;
    logic [data_width-1:0]  r_data;
    logic                   r_last;
    logic [switch_bits-1:0] r_chan;
    logic                   r_lock;
    logic [switch_bits-1:0] r_lock_chan;
    logic [switch_bits-1:0] r_rr_ptr;

    logic                   w_load;
    logic [switch_bits-1:0] w_rr_idx;
    logic                   w_rr_found;
    logic [switch_bits-1:0] w_cand;
    logic                   w_gnt_ok;
    logic                   w_xfer;
    logic [data_width-1:0]  w_cand_data;

    rr_arbiter #(.switch_bits(switch_bits)) u_rr_arbiter (
        .i_req   (in_valid),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_rr_idx),
        .o_found (w_rr_found)
    );

    assign w_load = !r_valid || o_ready;

    // Lock overrides both mode and sel until the packet's last beat moves.
    always_comb begin
        w_cand   = sel;
        w_gnt_ok = 1'b0;
        if (r_lock) begin
            w_cand   = r_lock_chan;
            w_gnt_ok = in_valid[r_lock_chan];
        end else if (mode == MODE_RR) begin
            w_cand   = w_rr_idx;
            w_gnt_ok = w_rr_found;
        end else begin
            w_gnt_ok = in_valid[sel];
        end
    end

    assign w_xfer = w_load && w_gnt_ok;

    always_comb begin
        w_cand_data = '0;
        in_ready    = '0;
        for (int unsigned i = 0; i < n_cell; i++) begin
            if (w_cand == switch_bits'(i)) begin
                w_cand_data = in_data[i*data_width +: data_width];
                in_ready[i] = rst_n && w_xfer;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_last      <= 1'b0;
            r_chan      <= '0;
            r_lock      <= 1'b0;
            r_lock_chan <= '0;
            r_rr_ptr    <= '1;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_data  <= w_cand_data;
            r_last  <= in_last[w_cand];
            r_chan  <= w_cand;
            if (mode == MODE_RR && !r_lock) begin
                r_rr_ptr <= w_cand;
            end
            if (in_last[w_cand]) begin
                r_lock <= 1'b0;
            end else begin
                r_lock      <= 1'b1;
                r_lock_chan <= w_cand;
            end
        end else if (o_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;
    assign o_chan  = r_chan;

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench for stream_mux (4 channels, 8-bit data) with immediate-assertion checks.
module tb_stream_mux;

    logic        clk;
    logic        rst_n;
    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_last;
    logic [3:0]  in_ready;
    logic        o_valid;
    logic [7:0]  o_data;
    logic        o_last;
    logic [1:0]  o_chan;
    logic        o_ready;

    logic [7:0]  dat [4];
    int          n_tests;
    int          n_fail;

    assign in_data = {dat[3], dat[2], dat[1], dat[0]};

    stream_mux #(.switch_bits(2), .data_width(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .sel      (sel),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_last   (o_last),
        .o_chan   (o_chan),
        .o_ready  (o_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [1:0] ch, input logic [7:0] d, input logic l);
        chk({tag, "_valid"}, 32'(o_valid), 32'd1);
        chk({tag, "_chan"},  32'(o_chan),  32'(ch));
        chk({tag, "_data"},  32'(o_data),  32'(d));
        chk({tag, "_last"},  32'(o_last),  32'(l));
    endtask

    logic [1:0] rr_chan [6];
    logic [7:0] rr_data [6];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rr_chan = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        rr_data = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10, 8'h11};
        for (int i = 0; i < 4; i++) dat[i] = 8'h10 + 8'(i);

        // Reset with every channel requesting
        rst_n    = 1'b0;
        mode     = 1'b1;
        sel      = 2'd0;
        in_valid = 4'hF;
        in_last  = 4'hF;
        o_ready  = 1'b1;
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 32'h0);
        chk("rst_o_valid",  32'(o_valid),  32'h0);
        chk("rst_o_data",   32'(o_data),   32'h0);
        chk("rst_o_chan",   32'(o_chan),   32'h0);
        chk("rst_o_last",   32'(o_last),   32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rr_first_ready", 32'(in_ready), 32'h1);

        // Round-robin fairness, single-beat packets
        for (int k = 0; k < 6; k++) begin
            tick();
            chk_out($sformatf("rr_%0d", k), rr_chan[k], rr_data[k], 1'b1);
        end

        // Packet lock on ch2 (rr_ptr is now 1)
        in_valid = 4'b0111;
        in_last  = 4'b0011;
        dat[2]   = 8'hA0;
        #1;
        chk("lock_ready0", 32'(in_ready), 32'b0100);
        tick();
        chk_out("lock_b0", 2'd2, 8'hA0, 1'b0);
        dat[2]   = 8'hA1;
        in_valid = 4'hF;
        mode     = 1'b0;
        sel      = 2'd0;
        #1;
        chk("lock_ready1", 32'(in_ready), 32'b0100);
        tick();
        chk_out("lock_b1", 2'd2, 8'hA1, 1'b0);
        dat[2]  = 8'hA2;
        in_last = 4'hF;
        tick();
        chk_out("lock_b2", 2'd2, 8'hA2, 1'b1);
        dat[2] = 8'h12;
        mode   = 1'b1;
        #1;
        chk("lock_resume_ready", 32'(in_ready), 32'b1000);
        tick();
        chk_out("lock_resume", 2'd3, 8'h13, 1'b1);

        // Backpressure with ch3 beat held
        o_ready = 1'b0;
        #1;
        chk("bp_ready_low", 32'(in_ready), 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk_out($sformatf("bp_hold_%0d", k), 2'd3, 8'h13, 1'b1);
            chk($sformatf("bp_ready_%0d", k), 32'(in_ready), 32'h0);
        end
        o_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'b0001);
        tick();
        chk_out("bp_no_bubble", 2'd0, 8'h10, 1'b1);

        // Select mode, sel channel idle
        mode     = 1'b0;
        sel      = 2'd1;
        in_valid = 4'b1101;
        #1;
        chk("sel_idle_ready", 32'(in_ready), 32'h0);
        tick();
        chk("sel_idle_valid", 32'(o_valid), 32'h0);
        chk("sel_idle_data",  32'(o_data),  32'h10);
        chk("sel_idle_chan",  32'(o_chan),  32'h0);
        in_valid = 4'hF;
        in_last  = 4'h0;
        dat[1]   = 8'hB0;
        #1;
        chk("sel_ready", 32'(in_ready), 32'b0010);
        tick();
        chk_out("sel_b0", 2'd1, 8'hB0, 1'b0);
        sel    = 2'd3;
        dat[1] = 8'hB1;
        #1;
        chk("sel_change_ready", 32'(in_ready), 32'b0010);
        tick();
        chk_out("sel_b1", 2'd1, 8'hB1, 1'b0);
        dat[1]  = 8'hB2;
        in_last = 4'b0010;
        tick();
        chk_out("sel_b2", 2'd1, 8'hB2, 1'b1);
        #1;
        chk("sel_new_ready", 32'(in_ready), 32'b1000);
        tick();
        chk_out("sel_ch3_lock", 2'd3, 8'h13, 1'b0);

        // Locked channel drops valid: stall even in RR mode with others valid
        in_valid = 4'b0111;
        mode     = 1'b1;
        #1;
        chk("stall_ready", 32'(in_ready), 32'h0);
        tick();
        chk("stall_valid", 32'(o_valid), 32'h0);
        in_valid = 4'hF;
        #1;
        chk("stall_resume_ready", 32'(in_ready), 32'b1000);

        // Async reset mid-packet on ch3
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(o_valid),  32'h0);
        chk("mrst_data",  32'(o_data),   32'h0);
        chk("mrst_chan",  32'(o_chan),   32'h0);
        chk("mrst_ready", 32'(in_ready), 32'h0);
        tick();
        in_last = 4'hF;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mrst_first_ready", 32'(in_ready), 32'b0001);
        tick();
        chk_out("mrst_first", 2'd0, 8'h10, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
